// File: rtl/moore_seq_ctrl.sv
// Serialises words MSB-first into an external Moore detector and
// counts detector hits per word plus a saturating grand total.
//
// Ports:
//   clk, reset       clock, async active-low reset
//   in_valid/ready   word handshake (ready only in IDLE)
//   in_data/len/clr  word, bit count (0 or >DATA_W = DATA_W), clear
//   abort            cancel the word in progress (ignored in IDLE)
//   fsm_x/rst/z      serial bit, detector reset, detector output
//   busy, done       word in progress, completion pulse
//   hit_count        hits in the last completed word
//   total_hits       saturating hits over all completed words
module moore_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int TOT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_len,
  input  logic              in_clr,
  input  logic              abort,
  output logic              fsm_x,
  output logic              fsm_rst,
  input  logic              fsm_z,
  output logic              busy,
  output logic              done,
  output logic [3:0]        hit_count,
  output logic [TOT_W-1:0]  total_hits
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [TOT_W-1:0] TMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bits;
  logic              first;
  logic [3:0]        wcnt;

  logic [CW-1:0]     eff_len;
  logic [3:0]        wnext;
  logic [TOT_W:0]    tsum;
  logic [TOT_W-1:0]  tnext;

  always_comb begin
    eff_len = FULL;
    if (in_len != 4'd0 && int'(in_len) <= DATA_W)
      eff_len = CW'(in_len);
  end

  // Word count including this cycle's z sample; held at 15 so
  // wide words cannot wrap the 4-bit count.
  always_comb begin
    wnext = wcnt;
    if (fsm_z && wcnt != 4'hF)
      wnext = wcnt + 4'd1;
  end

  always_comb begin
    tsum  = {1'b0, total_hits} + (TOT_W + 1)'(wnext);
    tnext = tsum[TOT_W] ? TMAX : tsum[TOT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bits       <= '0;
      first      <= 1'b0;
      wcnt       <= 4'd0;
      fsm_x      <= 1'b0;
      fsm_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b1;
      hit_count  <= 4'd0;
      total_hits <= '0;
    end else begin
      done    <= 1'b0;
      fsm_rst <= 1'b0;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        fsm_x    <= 1'b0;
        busy     <= 1'b0;
        in_ready <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_valid && in_ready && !abort) begin
              shreg    <= in_data;
              bits     <= eff_len;
              wcnt     <= 4'd0;
              fsm_x    <= 1'b0;
              fsm_rst  <= in_clr;
              busy     <= 1'b1;
              in_ready <= 1'b0;
              state    <= LOAD;
            end
          end
          LOAD: begin
            fsm_x <= shreg[DATA_W-1];
            shreg <= shreg << 1;
            first <= 1'b1;
            state <= SHIFT;
          end
          SHIFT: begin
            // z in the first SHIFT cycle still reflects the
            // previous word's tail, so it is skipped.
            first <= 1'b0;
            if (!first)
              wcnt <= wnext;
            if (bits == ONE) begin
              fsm_x <= 1'b0;
              state <= DRAIN;
            end else begin
              fsm_x <= shreg[DATA_W-1];
              shreg <= shreg << 1;
              bits  <= bits - ONE;
            end
          end
          DRAIN: begin
            wcnt       <= wnext;
            hit_count  <= wnext;
            total_hits <= tnext;
            done       <= 1'b1;
            fsm_x      <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
